// File: rtl/svc_accum_window.sv
// Windowed-sum controller: gathers win_len samples into an internal pipelined
// accumulator, waits out its latency, presents the sum, then clears for the next window.

module svc_accumulator #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] val,
  output logic [WIDTH-1:0] acc
);

  generate
    if (STAGES == 0) begin : g_direct
      always_ff @(posedge clk) begin
        if (!rst_n || clr) acc <= '0;
        else if (en)       acc <= acc + val;
      end
    end else begin : g_pipe
      localparam int unsigned NS = STAGES;
      logic [NS-1:0]    en_p;
      logic [WIDTH-1:0] val_p [NS];

      // clr flushes in-flight samples too, so an aborted window leaves no residue
      always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
          en_p <= '0;
          acc  <= '0;
        end else begin
          en_p[0] <= en;
          for (int unsigned i = 1; i < NS; i++) en_p[i] <= en_p[i-1];
          if (en_p[NS-1]) acc <= acc + val_p[NS-1];
        end
      end

      always_ff @(posedge clk) begin
        val_p[0] <= val;
        for (int unsigned i = 1; i < NS; i++) val_p[i] <= val_p[i-1];
      end
    end
  endgenerate

endmodule

module svc_accum_window #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int LEN_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LEN_W-1:0] win_len,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [LEN_W-1:0] out_len,
  output logic             busy
);

  localparam int DW = (STAGES > 0) ? $clog2(STAGES + 1) : 1;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    OUT   = 2'd2
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] count;
  logic [LEN_W-1:0] len_q;
  logic [DW-1:0]    dcnt;

  logic             accept;
  logic             handshake;
  logic             clr;
  logic             last;
  logic [LEN_W-1:0] lat_len;
  logic [LEN_W-1:0] eff_len;
  logic [WIDTH-1:0] acc;

  always_comb begin
    in_ready  = (state == ACCUM) && !abort;
    accept    = in_valid && in_ready;
    handshake = (state == OUT) && out_ready && !abort;
    clr       = abort || handshake;
    lat_len   = (win_len == '0) ? LEN_W'(1) : win_len;
    // first sample of a window compares against the length being latched this cycle
    eff_len   = (count == '0) ? lat_len : len_q;
    last      = (count == eff_len - LEN_W'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
      count <= '0;
      dcnt  <= '0;
      len_q <= LEN_W'(1);
    end else if (abort) begin
      state <= ACCUM;
      count <= '0;
      dcnt  <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            if (count == '0) len_q <= lat_len;
            if (last) begin
              state <= DRAIN;
              dcnt  <= DW'(STAGES);
            end else begin
              count <= count + LEN_W'(1);
            end
          end
        end
        DRAIN: begin
          if (dcnt == '0) state <= OUT;
          else            dcnt  <= dcnt - DW'(1);
        end
        OUT: begin
          if (out_ready) begin
            state <= ACCUM;
            count <= '0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  svc_accumulator #(
    .WIDTH (WIDTH),
    .STAGES(STAGES)
  ) u_acc (
    .clk  (clk),
    .rst_n(~rst),
    .en   (accept),
    .clr  (clr),
    .val  (in_data),
    .acc  (acc)
  );

  always_comb begin
    out_valid = (state == OUT);
    out_sum   = out_valid ? acc : '0;
    out_len   = out_valid ? len_q : '0;
    busy      = !((state == ACCUM) && (count == '0));
  end

endmodule

// File: tb/tb_svc_accum_window.sv
// Bench for svc_accum_window: window-level reference model feeding a result
// scoreboard, directed scenarios, then randomized traffic.

module tb_svc_accum_window;

  localparam int S = 4;

  typedef struct {
    logic [31:0] sum;
    logic [7:0]  len;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  win_len;
  logic        abort;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic [7:0]  out_len;
  logic        busy;

  logic [7:0]  z_win_len;
  logic        z_in_valid;
  logic        z_in_ready;
  logic [31:0] z_in_data;
  logic        z_out_valid;
  logic        z_out_ready;
  logic [31:0] z_out_sum;
  logic [7:0]  z_out_len;
  logic        z_busy;

  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned cyc   = 0;

  logic [31:0] win_q[$];
  res_t        sb[$];
  int          mlen    = 1;
  bit          pending = 1'b0;
  int unsigned due     = 0;

  svc_accum_window #(.WIDTH(32), .STAGES(S), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .win_len(win_len), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_len(out_len), .busy(busy)
  );

  svc_accum_window #(.WIDTH(32), .STAGES(0), .LEN_W(8)) dut_z (
    .clk(clk), .rst(rst), .win_len(z_win_len), .abort(1'b0),
    .in_valid(z_in_valid), .in_ready(z_in_ready), .in_data(z_in_data),
    .out_valid(z_out_valid), .out_ready(z_out_ready), .out_sum(z_out_sum),
    .out_len(z_out_len), .busy(z_busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every output handshake pops one expected window result.
  initial begin
    bit          hold_v = 1'b0;
    logic [31:0] hold_s = '0;
    res_t        r;
    forever begin
      @(negedge clk);
      if (out_valid && hold_v) chk("sum_stable", out_sum, hold_s);
      if (out_valid && out_ready && !abort && !rst) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 32'(out_valid), 32'(0));
        end else begin
          r = sb.pop_front();
          chk("out_sum", out_sum, r.sum);
          chk("out_len", 32'(out_len), 32'(r.len));
        end
      end
      hold_v = out_valid && !out_ready && !abort && !rst;
      hold_s = out_sum;
    end
  end

  // One clock of the main DUT: check handshake-level outputs against the
  // window model, then advance the model to what the coming edge will do.
  task automatic cycle();
    bit          ev, er, eb;
    logic [31:0] s;
    res_t        r;
    @(negedge clk);
    ev = pending && (cyc >= due);
    er = !pending && !abort;
    eb = pending || (win_q.size() != 0);
    chk("in_ready", 32'(in_ready), 32'(er));
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("busy", 32'(busy), 32'(eb));
    if (rst || abort) begin
      win_q.delete();
      if (pending) sb.delete();
      pending = 1'b0;
    end else if (pending) begin
      if (ev && out_ready) pending = 1'b0;
    end else if (in_valid) begin
      if (win_q.size() == 0) mlen = (win_len == 8'd0) ? 1 : int'(win_len);
      win_q.push_back(in_data);
      if (win_q.size() == mlen) begin
        s = '0;
        foreach (win_q[i]) s += win_q[i];
        r.sum = s;
        r.len = 8'(mlen);
        sb.push_back(r);
        pending = 1'b1;
        due = cyc + 1 + S + 1;
        win_q.delete();
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && (pending || sb.size() != 0); i++) cycle();
    chk("drain_timeout", 32'(pending || sb.size() != 0), 32'(0));
  endtask

  initial begin
    rst = 1'b1; win_len = 8'd4; abort = 1'b0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b1;
    z_win_len = 8'd0; z_in_valid = 1'b0; z_in_data = '0; z_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_sum", out_sum, 32'h0);
    chk("rst_out_len", 32'(out_len), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);

    // Basic window of four, latency covered by per-cycle out_valid checks
    win_len = 8'd4;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(i);
      cycle();
    end
    in_valid = 1'b0;
    wait_idle();

    // STAGES=0 instance, zero length treated as one
    z_win_len = 8'd0; z_in_valid = 1'b1; z_in_data = 32'd7;
    chk("z_in_ready", 32'(z_in_ready), 32'h1);
    cycle();
    z_in_valid = 1'b0;
    chk("z_valid_early", 32'(z_out_valid), 32'h0);
    chk("z_busy", 32'(z_busy), 32'h1);
    cycle();
    chk("z_valid", 32'(z_out_valid), 32'h1);
    chk("z_sum", z_out_sum, 32'd7);
    chk("z_len", 32'(z_out_len), 32'd1);
    z_out_ready = 1'b1;
    cycle();
    chk("z_valid_after", 32'(z_out_valid), 32'h0);
    chk("z_ready_after", 32'(z_in_ready), 32'h1);
    chk("z_busy_after", 32'(z_busy), 32'h0);

    // Wraparound, then a window proving the accumulator was cleared
    win_len = 8'd2;
    send(32'hFFFF_FFFF);
    send(32'h0000_0002);
    wait_idle();
    send(32'd5);
    send(32'd5);
    wait_idle();

    // Backpressure with in_valid high and a mid-hold length change
    win_len = 8'd3;
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = $urandom;
      cycle();
    end
    win_len = 8'd9;
    for (int i = 0; i < S + 1 + 20; i++) begin
      in_data = $urandom;
      cycle();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_data = $urandom;
      cycle();
    end
    in_valid = 1'b0;
    wait_idle();

    // Abort on the second sample
    win_len = 8'd3;
    send(32'd1);
    abort = 1'b1;
    send(32'd2);
    abort = 1'b0;
    send(32'd4);
    send(32'd5);
    send(32'd6);
    wait_idle();

    // Reset while draining
    send(32'd1);
    send(32'd2);
    send(32'd3);
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_drain_valid", 32'(out_valid), 32'h0);
    chk("rst_drain_ready", 32'(in_ready), 32'h1);
    chk("rst_drain_busy", 32'(busy), 32'h0);
    win_len = 8'd2;
    send(32'd8);
    send(32'd8);
    wait_idle();

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      win_len   = 8'($urandom_range(0, 6));
      out_ready = ($urandom_range(0, 2) != 0);
      abort     = ($urandom_range(0, 59) == 0);
      cycle();
    end
    in_valid = 1'b0; abort = 1'b0; out_ready = 1'b1;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
